// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, optional parity, 1/2 stop bits and a FWFT receive FIFO.
// Define UART_RX_BREAK_DETECT_EN to add break detection (rx_break output, BREAK state).
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          CLK100MHZ,
  input  logic                          CPU_RESETN,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overflow,
  input  logic                          overflow_clr,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                          rx_break,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DW  = $clog2(DIV);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DivMax = DW'(DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop
`ifdef UART_RX_BREAK_DETECT_EN
    , StBreak
`endif
  } state_e;

  logic                 rxd_meta, rxd_s;
  state_e               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [3:0]           tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 frm_q, frm_d;
  logic                 tick, mid, start_det, push, frm_now;
  logic [7:0]           data_ext;
  logic [9:0]           push_word;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 stop_hi_q, stop_hi_d;
  logic                 brk_q, brk_d;
`endif

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  assign tick = (div_q == DivMax);
  assign mid  = tick && (tick_q == 4'd7);

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
    if (start_det) div_d = '0;
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    frm_d     = frm_q;
    start_det = 1'b0;
    push      = 1'b0;
    frm_now   = frm_q | ~rxd_s;
    data_ext  = '0;
    data_ext[DATA_BITS-1:0] = shreg_q;
    push_word = {frm_now, par_q, data_ext};
`ifdef UART_RX_BREAK_DETECT_EN
    stop_hi_d = stop_hi_q;
    brk_d     = 1'b0;
`endif
    if (tick && state_q != StIdle) tick_d = tick_q + 4'd1;
    unique case (state_q)
      StIdle: begin
        if (!rxd_s) begin
          state_d   = StStart;
          tick_d    = '0;
          start_det = 1'b1;
        end
      end
      StStart: begin
        if (mid) begin
          if (rxd_s) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            bit_d   = '0;
            par_d   = 1'b0;
            frm_d   = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            stop_hi_d = 1'b0;
`endif
          end
        end
      end
      StData: begin
        if (mid) begin
          shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (mid) begin
          // Odd mode wants an odd number of ones across data and parity bit
          par_d   = (PARITY == 1) ? ~(^shreg_q ^ rxd_s) : (^shreg_q ^ rxd_s);
          bit_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (mid) begin
          frm_d = frm_now;
`ifdef UART_RX_BREAK_DETECT_EN
          stop_hi_d = stop_hi_q | rxd_s;
`endif
          if (bit_q == 3'(STOP_BITS - 1)) begin
            state_d = StIdle;
`ifdef UART_RX_BREAK_DETECT_EN
            if (shreg_q == '0 && !(stop_hi_q | rxd_s)) begin
              brk_d   = 1'b1;
              state_d = StBreak;
              tick_d  = '0;
            end else begin
              push = 1'b1;
            end
`else
            push = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      StBreak: begin
        // Line must be high for a full bit period of consecutive ticks
        if (!rxd_s) begin
          tick_d = '0;
        end else if (tick) begin
          if (tick_q == 4'd15) state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= StIdle;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      stop_hi_q <= 1'b0;
      brk_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      frm_q   <= frm_d;
`ifdef UART_RX_BREAK_DETECT_EN
      stop_hi_q <= stop_hi_d;
      brk_q     <= brk_d;
`endif
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  assign rx_break = brk_q;
`endif

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic          full, pop, wr_en;
  logic [9:0]    head;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = rx_valid && rx_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (wr_en) mem[wr_q] <= push_word;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      count_q <= count_d;
      // Set has priority over a coincident clear
      if (push && full && !pop) overflow <= 1'b1;
      else if (overflow_clr)    overflow <= 1'b0;
    end
  end

  assign head          = mem[rd_q];
  assign rx_valid      = (count_q != '0);
  assign fifo_count    = count_q;
  assign rx_data       = rx_valid ? head[7:0] : 8'h00;
  assign rx_parity_err = rx_valid & head[8];
  assign rx_frame_err  = rx_valid & head[9];

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesisable, parametrised UART receiver with 16x oversampling, configurable frame format and a first-word-fall-through receive FIFO.
- Sits between the board UART_TXD_IN pin and the CPU MMIO/peripheral bus.
- Replaces the fixed 8N1, 9600-baud, single-byte receive path used so far.
- Adds the following, which the old path does not have:
  - parity checking
  - configurable stop bits
  - start-bit glitch rejection
  - per-byte error flags
  - buffered output with a valid/ready handshake
  - sticky overflow reporting

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. DIV = CLK_FREQ/(BAUD*16), integer floor; DIV must be >= 2.
- DATA_BITS, 8, payload bits per frame, range 5..8, LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- FIFO_DEPTH, 16, number of receive FIFO entries; must be a power of 2, minimum 2.

Ports:
- CLK100MHZ  in  1  system clock; all logic is clocked on its rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input, asynchronous to the clock, idle high.
- rx_data  out  8  FIFO head byte; unused upper bits read 0 when DATA_BITS < 8.
- rx_parity_err  out  1  parity error flag of the head entry.
- rx_frame_err  out  1  framing error flag of the head entry (a stop bit sampled 0).
- rx_valid  out  1  FIFO is non-empty; the head entry is presented on rx_data and its flags.
- rx_ready  in  1  consumer accepts the head entry.
- overflow  out  1  sticky flag: set when a byte was dropped because the FIFO was full.
- overflow_clr  in  1  single-cycle pulse that clears overflow.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Internal state: synchroniser flops = 1, FSM = IDLE, tick and bit counters = 0, FIFO pointers = 0.
  - Outputs: rx_data = 0, rx_parity_err = 0, rx_frame_err = 0, rx_valid = 0, overflow = 0, fifo_count = 0.
  - Reset mid-frame discards the partial frame; there is no output afterwards until a new start edge arrives.
- Input synchroniser: rxd passes through a 2-flop synchroniser (2 cycles latency) to give rxd_s.
- Baud tick generator:
  - Divider counts 0..DIV-1 and pulses tick for one cycle at DIV-1.
  - The divider is free-running, but is reset to 0 in the cycle an IDLE falling edge is detected.
- Each bit period is 16 ticks. Sampling happens when the per-bit tick counter equals 7 (mid-bit).
- FSM states:
  - IDLE: on rxd_s = 0, go to START and clear the tick counter.
  - START: at mid-bit, if rxd_s = 1 it is a glitch; return to IDLE and push nothing. Otherwise go to DATA.
  - DATA: sample DATA_BITS bits LSB first into a shift register, one per 16 ticks, then go to PARITY if PARITY != 0, else to STOP.
  - PARITY: sample the parity bit. Error if odd mode and XOR(data, bit) = 0, or even mode and XOR(data, bit) = 1.
  - STOP:
    - Sample STOP_BITS stop bits.
    - frame_err = OR of the inverted samples.
    - Push {frame_err, parity_err, data} at the mid-bit sample of the final stop bit, then go to IDLE.
    - That last stop bit may be shortened: a new start edge is accepted from the following cycle.
- Latency: rx_valid rises 1 cycle after the push when the FIFO was empty (registered count).
- FIFO:
  - First-word-fall-through; the head entry is stable while rx_valid = 1 and rx_ready = 0.
  - A pop occurs when rx_valid && rx_ready.
  - Pointers are FIFO_DEPTH wrap-around binary counters.
  - Push when full and no pop in the same cycle: the byte is dropped and overflow is set; FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both take effect, count stays FIFO_DEPTH, and overflow is not set.
  - Push and pop in the same cycle when empty: the push takes effect only, since there is no valid head.
- overflow:
  - Stays set until an overflow_clr pulse.
  - If set and clear happen in the same cycle, set wins.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - Adds output port rx_break (1 bit, reset 0).
  - A frame whose data bits and stop bits are all 0 does not push to the FIFO; instead rx_break pulses high for 1 cycle.
  - The FSM then waits in a BREAK state until rxd_s has been 1 for 16 consecutive ticks, then returns to IDLE.
- Undefined:
  - The rx_break port and the BREAK state are absent.
  - An all-zero frame is pushed as data 0x00 with frame_err = 1.

Test Plan:
- 8N1 at 9600 baud: send 0x55, hold rx_ready = 0 → rx_valid rises about 9.5 bit times (about 990 us) after the start edge; rx_data = 0x55; both error flags = 0; fifo_count = 1.
- PARITY = 2, send 0xA5 with parity bit 1 (wrong) → rx_data = 0xA5, rx_parity_err = 1. Resend with parity bit 0 → rx_parity_err = 0.
- Send 0x3C with the stop bit forced to 0 → rx_data = 0x3C, rx_frame_err = 1. The following correct byte 0x3D is received with no errors.
- 3 us low pulse on idle rxd → no push, fifo_count stays 0, FSM returns to IDLE.
- rx_ready = 0, send 17 bytes 0x00..0x10 → fifo_count = 16, overflow = 1, entries read back 0x00..0x0F.
  - Then pulse overflow_clr → overflow = 0.
  - Repeat with rx_ready pulsed during the 17th push → no overflow.
- Assert CPU_RESETN = 0 during data bit 4 of 0xF0, then release and send 0x81 → only 0x81 is received.
- With UART_RX_BREAK_DETECT_EN defined: hold rxd low for 20 bit times → one rx_break pulse, no FIFO push; the next byte 0x42 is received normally.
